// File: rtl/traffic_lcd_writer.sv
// traffic_lcd_writer
//   Display stage for the two-way traffic-light controller. Drives an
//   HD44780-compatible 16x2 LCD (8-bit, write-only). After power-up it sends
//   the init sequence, then repeatedly writes line 1 as "A:<colour> <tens><units>"
//   for direction A and line 2 as "B:..." for direction B.
//
// Ports
//   clk            system clock, rising edge
//   rs             synchronous active-high reset
//   x1/v1/d1       direction A green/yellow/red lamps
//   x2/v2/d2       direction B green/yellow/red lamps
//   cnt1/cnt2      seconds remaining per direction (shown clamped to 99)
//   lcd_rs         0 = command, 1 = data
//   lcd_rw         tied 0 (write-only)
//   lcd_e          enable strobe
//   lcd_db         data bus
//   init_done      high once the init sequence has finished
//   frame_done     one-cycle pulse after the last byte of each frame
module traffic_lcd_writer #(
  parameter int unsigned T_PWRUP  = 1000000,
  parameter int unsigned T_E_HIGH = 12,
  parameter int unsigned T_CMD    = 2500,
  parameter int unsigned T_CLR    = 100000
) (
  input  logic       clk,
  input  logic       rs,
  input  logic       x1,
  input  logic       v1,
  input  logic       d1,
  input  logic       x2,
  input  logic       v2,
  input  logic       d2,
  input  logic [7:0] cnt1,
  input  logic [7:0] cnt2,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [7:0] lcd_db,
  output logic       init_done,
  output logic       frame_done
);

  typedef enum logic [2:0] {
    S_PWRUP,
    S_SETUP,
    S_PULSE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] tmr_q, tmr_d;
  logic [3:0]  idx_q, idx_d;
  logic        init_q, init_d;
  logic        lcd_rs_q, lcd_rs_d;
  logic [7:0]  lcd_db_q, lcd_db_d;

  // Per-frame snapshot of the inputs
  logic [2:0]  lamp1_q, lamp2_q;
  logic [7:0]  val1_q, val2_q;

  logic [7:0]  col1, col2, tens1, units1, tens2, units2;
  logic [31:0] wait_len;
  logic        load;

  function automatic logic [7:0] colour(input logic [2:0] gyr);
    case (gyr)
      3'b100:  colour = 8'h47; // 'G'
      3'b010:  colour = 8'h59; // 'Y'
      3'b001:  colour = 8'h52; // 'R'
      default: colour = 8'h2D; // '-'
    endcase
  endfunction

  function automatic logic [15:0] digits(input logic [7:0] v);
    logic [7:0] c;
    c = (v > 8'd99) ? 8'd99 : v;
    digits = {8'h30 + c / 8'd10, 8'h30 + c % 8'd10};
  endfunction

  always_comb begin
    col1 = colour(lamp1_q);
    col2 = colour(lamp2_q);
    {tens1, units1} = digits(val1_q);
    {tens2, units2} = digits(val2_q);
  end

  // Only the clear-display command needs the long wait.
  assign wait_len = (!lcd_rs_q && lcd_db_q == 8'h01) ? T_CLR : T_CMD;

  always_comb begin
    state_d  = state_q;
    tmr_d    = tmr_q + 32'd1;
    idx_d    = idx_q;
    init_d   = init_q;
    lcd_rs_d = lcd_rs_q;
    lcd_db_d = lcd_db_q;
    load     = 1'b0;

    case (state_q)
      S_PWRUP: begin
        if (tmr_q == T_PWRUP - 1) begin
          state_d = S_SETUP;
          tmr_d   = '0;
          idx_d   = '0;
          load    = 1'b1;
        end
      end
      S_SETUP: begin
        state_d = S_PULSE;
        tmr_d   = '0;
      end
      S_PULSE: begin
        if (tmr_q == T_E_HIGH - 1) begin
          state_d = S_WAIT;
          tmr_d   = '0;
        end
      end
      S_WAIT: begin
        if (tmr_q == wait_len - 32'd1) begin
          tmr_d = '0;
          if (!init_q && idx_q == 4'd3) begin
            init_d  = 1'b1;
            idx_d   = '0;
            state_d = S_SETUP;
            load    = 1'b1;
          end else if (init_q && idx_q == 4'd13) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = S_SETUP;
            load    = 1'b1;
          end
        end
      end
      S_DONE: begin
        idx_d   = '0;
        tmr_d   = '0;
        state_d = S_SETUP;
        load    = 1'b1;
      end
      default: state_d = S_PWRUP;
    endcase

    // Bus value is latched on entry to SETUP and held through WAIT. The frame's
    // first byte is constant, so it never depends on a snapshot not yet taken.
    if (load) begin
      if (!init_d) begin
        lcd_rs_d = 1'b0;
        case (idx_d)
          4'd0:    lcd_db_d = 8'h38;
          4'd1:    lcd_db_d = 8'h0C;
          4'd2:    lcd_db_d = 8'h06;
          default: lcd_db_d = 8'h01;
        endcase
      end else begin
        lcd_rs_d = !(idx_d == 4'd0 || idx_d == 4'd7);
        case (idx_d)
          4'd0:    lcd_db_d = 8'h80;
          4'd1:    lcd_db_d = 8'h41;
          4'd2:    lcd_db_d = 8'h3A;
          4'd3:    lcd_db_d = col1;
          4'd4:    lcd_db_d = 8'h20;
          4'd5:    lcd_db_d = tens1;
          4'd6:    lcd_db_d = units1;
          4'd7:    lcd_db_d = 8'hC0;
          4'd8:    lcd_db_d = 8'h42;
          4'd9:    lcd_db_d = 8'h3A;
          4'd10:   lcd_db_d = col2;
          4'd11:   lcd_db_d = 8'h20;
          4'd12:   lcd_db_d = tens2;
          default: lcd_db_d = units2;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rs) begin
      state_q  <= S_PWRUP;
      tmr_q    <= '0;
      idx_q    <= '0;
      init_q   <= 1'b0;
      lcd_rs_q <= 1'b0;
      lcd_db_q <= '0;
      lamp1_q  <= '0;
      lamp2_q  <= '0;
      val1_q   <= '0;
      val2_q   <= '0;
    end else begin
      state_q  <= state_d;
      tmr_q    <= tmr_d;
      idx_q    <= idx_d;
      init_q   <= init_d;
      lcd_rs_q <= lcd_rs_d;
      lcd_db_q <= lcd_db_d;
      // First cycle of a frame is the SETUP of its first byte.
      if (state_q == S_SETUP && init_q && idx_q == 4'd0) begin
        lamp1_q <= {x1, v1, d1};
        lamp2_q <= {x2, v2, d2};
        val1_q  <= cnt1;
        val2_q  <= cnt2;
      end
    end
  end

  assign lcd_e      = (state_q == S_PULSE);
  assign frame_done = (state_q == S_DONE);
  assign init_done  = init_q;
  assign lcd_rw     = 1'b0;
  assign lcd_rs     = lcd_rs_q;
  assign lcd_db     = lcd_db_q;

endmodule

// File: tb/tb_traffic_lcd_writer.sv
// tb_traffic_lcd_writer
//   Scoreboard bench for traffic_lcd_writer: the stimulus process queues the
//   expected {lcd_rs, lcd_db} of each byte; a monitor pops one entry per lcd_e
//   pulse and also checks pulse width, inter-pulse gaps, init_done and
//   frame_done timing.
module tb_traffic_lcd_writer;

  localparam int TP = 20;
  localparam int TE = 2;
  localparam int TC = 5;
  localparam int TL = 10;

  logic       clk = 1'b0;
  logic       rs  = 1'b1;
  logic       x1, v1, d1, x2, v2, d2;
  logic [7:0] cnt1, cnt2;
  logic       lcd_rs, lcd_rw, lcd_e, init_done, frame_done;
  logic [7:0] lcd_db;

  traffic_lcd_writer #(
    .T_PWRUP (TP),
    .T_E_HIGH(TE),
    .T_CMD   (TC),
    .T_CLR   (TL)
  ) dut (
    .clk       (clk),
    .rs        (rs),
    .x1        (x1),
    .v1        (v1),
    .d1        (d1),
    .x2        (x2),
    .v2        (v2),
    .d2        (d2),
    .cnt1      (cnt1),
    .cnt2      (cnt2),
    .lcd_rs    (lcd_rs),
    .lcd_rw    (lcd_rw),
    .lcd_e     (lcd_e),
    .lcd_db    (lcd_db),
    .init_done (init_done),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [8:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  task automatic push_init();
    exp_q.push_back({1'b0, 8'h38});
    exp_q.push_back({1'b0, 8'h0C});
    exp_q.push_back({1'b0, 8'h06});
    exp_q.push_back({1'b0, 8'h01});
  endtask

  task automatic push_frame(input logic [7:0] c1, input logic [7:0] t1,
                            input logic [7:0] u1, input logic [7:0] c2,
                            input logic [7:0] t2, input logic [7:0] u2);
    exp_q.push_back({1'b0, 8'h80});
    exp_q.push_back({1'b1, 8'h41});
    exp_q.push_back({1'b1, 8'h3A});
    exp_q.push_back({1'b1, c1});
    exp_q.push_back({1'b1, 8'h20});
    exp_q.push_back({1'b1, t1});
    exp_q.push_back({1'b1, u1});
    exp_q.push_back({1'b0, 8'hC0});
    exp_q.push_back({1'b1, 8'h42});
    exp_q.push_back({1'b1, 8'h3A});
    exp_q.push_back({1'b1, c2});
    exp_q.push_back({1'b1, 8'h20});
    exp_q.push_back({1'b1, t2});
    exp_q.push_back({1'b1, u2});
  endtask

  // ---------------- monitor ----------------
  logic       prev_e, prev_id, first, fd_seen, fs_valid, clr_valid;
  int         high_cnt, low_cnt, prev_wait, fs, clr_fall;
  logic [8:0] last_b, popped;

  always @(negedge clk) begin
    if (rs) begin
      prev_e    = 1'b0;
      prev_id   = 1'b0;
      first     = 1'b1;
      fd_seen   = 1'b0;
      fs_valid  = 1'b0;
      clr_valid = 1'b0;
      high_cnt  = 0;
      low_cnt   = 0;
      prev_wait = TC;
      last_b    = '0;
    end else begin
      if (lcd_e && !prev_e) begin
        check("byte available", (exp_q.size() > 0) ? 1 : 0, 1);
        if (exp_q.size() > 0) begin
          popped = exp_q.pop_front();
          check("byte rs/db", int'({lcd_rs, lcd_db}), int'(popped));
          if (popped == {1'b0, 8'h80}) begin
            fs       = cyc - 1;
            fs_valid = 1'b1;
          end
        end
        check("gap before pulse", low_cnt,
              first ? TP + 1 : prev_wait + 1 + (fd_seen ? 1 : 0));
        last_b   = {lcd_rs, lcd_db};
        first    = 1'b0;
        fd_seen  = 1'b0;
        high_cnt = 1;
        low_cnt  = 0;
      end else if (lcd_e) begin
        high_cnt++;
      end else if (prev_e) begin
        check("pulse width", high_cnt, TE);
        check("bus held into wait", int'({lcd_rs, lcd_db}), int'(last_b));
        prev_wait = (last_b == {1'b0, 8'h01}) ? TL : TC;
        if (last_b == {1'b0, 8'h01}) begin
          clr_fall  = cyc;
          clr_valid = 1'b1;
        end
        low_cnt = 1;
      end else begin
        low_cnt++;
      end

      if (frame_done) begin
        fd_seen = 1'b1;
        check("frame_done after frame start", int'(fs_valid), 1);
        if (fs_valid) check("frame_done timing", cyc - fs, 14 * (1 + TE + TC));
        fs_valid = 1'b0;
      end
      if (init_done && !prev_id) begin
        check("init_done after clear", int'(clr_valid), 1);
        if (clr_valid) check("init_done timing", cyc - clr_fall, TL);
      end
      if (!init_done && prev_id) check("init_done sticky", int'(init_done), 1);
      prev_e  = lcd_e;
      prev_id = init_done;
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_fd(input int budget);
    int k;
    k = 0;
    do begin
      @(posedge clk);
      #1;
      k++;
    end while (!frame_done && k < budget);
    if (!frame_done) check("frame_done timeout", int'(frame_done), 1);
  endtask

  task automatic check_reset_outputs();
    check("reset lcd_e", int'(lcd_e), 0);
    check("reset lcd_db", int'(lcd_db), 0);
    check("reset lcd_rs", int'(lcd_rs), 0);
    check("reset lcd_rw", int'(lcd_rw), 0);
    check("reset init_done", int'(init_done), 0);
    check("reset frame_done", int'(frame_done), 0);
  endtask

  initial begin
    int k;
    x1 = 1'b1; v1 = 1'b0; d1 = 1'b0;
    x2 = 1'b0; v2 = 1'b0; d2 = 1'b1;
    cnt1 = 8'd15; cnt2 = 8'd20;
    rs = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    push_init();
    push_frame(8'h47, 8'h31, 8'h35, 8'h52, 8'h32, 8'h30);   // "A:G 15" "B:R 20"
    rs = 1'b0;

    wait_fd(400);
    cnt1 = 8'd150; cnt2 = 8'd7;
    push_frame(8'h47, 8'h39, 8'h39, 8'h52, 8'h30, 8'h37);   // "99" / "07"

    wait_fd(200);
    x1 = 1'b0; v1 = 1'b1; d1 = 1'b1;
    x2 = 1'b0; v2 = 1'b0; d2 = 1'b0;
    cnt1 = 8'd15; cnt2 = 8'd20;
    push_frame(8'h2D, 8'h31, 8'h35, 8'h2D, 8'h32, 8'h30);   // invalid lamps

    wait_fd(200);
    x1 = 1'b1; v1 = 1'b0; d1 = 1'b0; d2 = 1'b1;
    push_frame(8'h47, 8'h31, 8'h35, 8'h52, 8'h32, 8'h30);
    repeat (20) @(posedge clk);   // now inside the frame's 3rd byte
    #1;
    cnt1 = 8'd14;
    push_frame(8'h47, 8'h31, 8'h34, 8'h52, 8'h32, 8'h30);

    wait_fd(200);
    wait_fd(200);
    push_frame(8'h47, 8'h31, 8'h34, 8'h52, 8'h32, 8'h30);

    // Reset in the second cycle of the next frame's first pulse.
    k = 0;
    do begin
      @(posedge clk);
      #1;
      k++;
    end while (!lcd_e && k < 50);
    @(posedge clk);
    #1;
    check("pulse before reset", int'(lcd_e), 1);
    rs = 1'b1;
    @(posedge clk);
    #1;
    exp_q.delete();
    check_reset_outputs();
    push_init();
    push_frame(8'h47, 8'h31, 8'h34, 8'h52, 8'h32, 8'h30);
    repeat (2) @(posedge clk);
    #1;
    rs = 1'b0;

    wait_fd(400);
    check("scoreboard drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
